// File: rtl/out_alu_pkg.sv
// Shared ALU definitions: packed result layout helpers and capture FSM encoding.
package out_alu_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    ACK  = 1'b1
  } capState_e;

  // Packed result word is {id, carry, sum}, sum in the low bits.
  function automatic int resSize(input int dataSize, input int idSize);
    return idSize + 1 + dataSize;
  endfunction

  function automatic int carryPos(input int dataSize);
    return dataSize;
  endfunction

  function automatic int idLsb(input int dataSize);
    return dataSize + 1;
  endfunction

endpackage

// File: rtl/out_alu_if.sv
// Adder-side capture handshake and consumer-side drain handshake of the ALU output stage.
interface out_alu_if
  import out_alu_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int ID_SIZE    = 8,
  parameter int FIFO_DEPTH = 4
);

  localparam int RES_SIZE = resSize(DATA_SIZE, ID_SIZE);
  localparam int CNT_SIZE = $clog2(FIFO_DEPTH) + 1;

  logic                a_valid_res;
  logic [RES_SIZE-1:0] result_add;
  logic                sum_written;
  logic                ready_f_res;
  logic                res_valid;
  logic [RES_SIZE-1:0] res_data;
  logic                res_ready;
  logic [CNT_SIZE-1:0] fifo_count;

  modport slave (
    input  a_valid_res, result_add, res_ready,
    output sum_written, ready_f_res, res_valid, res_data, fifo_count
  );

  modport master (
    output a_valid_res, result_add, res_ready,
    input  sum_written, ready_f_res, res_valid, res_data, fifo_count
  );

endinterface

// File: rtl/out_alu_res_fifo.sv
// First-word-fall-through circular FIFO with a separate occupancy counter.
// The caller guarantees no push when full and no pop when empty.
module res_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) wrPtr_d = wrPtr_q + 1'b1;
    if (pop)  rdPtr_d = rdPtr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (push) mem_q[wrPtr_q] <= din;
    end
  end

  assign dout  = mem_q[rdPtr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/out_alu.sv
// ALU output collection stage: captures adder results once per handshake into a
// result FIFO and drains it to the consumer over valid/ready.
module out_alu
  import out_alu_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int ID_SIZE    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  out_alu_if.slave  bus
);

  localparam int RES_SIZE = resSize(DATA_SIZE, ID_SIZE);

  capState_e state_q;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;

  // ACK blocks a second push of the same result while the adder still holds valid.
  assign push = (state_q == WAIT) && bus.a_valid_res && !full;
  assign pop  = !empty && bus.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
    end else begin
      case (state_q)
        WAIT:    if (push) state_q <= ACK;
        ACK:     state_q <= WAIT;
        default: state_q <= WAIT;
      endcase
    end
  end

  res_fifo #(
    .WIDTH (RES_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.result_add),
    .pop   (pop),
    .dout  (bus.res_data),
    .full  (full),
    .empty (empty),
    .count (bus.fifo_count)
  );

  assign bus.sum_written = (state_q == ACK);
  assign bus.ready_f_res = !full;
  assign bus.res_valid   = !empty;

endmodule

// File: tb/tb_out_alu.sv
// Self-checking bench for out_alu: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the output stage.
module tb_out_alu;
  import out_alu_pkg::*;

  localparam int DATA_SIZE  = 16;
  localparam int ID_SIZE    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int RES_SIZE   = resSize(DATA_SIZE, ID_SIZE);

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  out_alu_if #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  out_alu #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: a queue of stored words and whether an acknowledge is owed this cycle.
  logic [RES_SIZE-1:0] modelQ [$];
  logic [RES_SIZE-1:0] dutPopQ [$];
  bit                  ackExp = 1'b0;
  bit                  doPush;
  bit                  doPop;
  int                  maxCount = 0;
  int                  prevCount = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modelQ.delete();
      ackExp = 1'b0;
    end else begin
      doPop  = (modelQ.size() != 0) && bus.res_ready;
      doPush = !ackExp && bus.a_valid_res && (modelQ.size() < FIFO_DEPTH);
      if (bus.res_valid && bus.res_ready) dutPopQ.push_back(bus.res_data);
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(bus.result_add);
      ackExp = doPush;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled mid low phase.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      checkOutput("sum_written", 32'(bus.sum_written), 32'(ackExp));
      checkOutput("res_valid", 32'(bus.res_valid), 32'(modelQ.size() != 0));
      checkOutput("fifo_count", 32'(bus.fifo_count), 32'(modelQ.size()));
      checkOutput("ready_f_res", 32'(bus.ready_f_res), 32'(modelQ.size() < FIFO_DEPTH));
      if (modelQ.size() != 0) checkOutput("res_data", 32'(bus.res_data), 32'(modelQ[0]));
      checkOutput("no_overflow", 32'(int'(bus.fifo_count) <= FIFO_DEPTH), 32'd1);
      if (prevCount == 0) checkOutput("no_underflow", 32'(int'(bus.fifo_count) <= 1), 32'd1);
      prevCount = int'(bus.fifo_count);
      if (int'(bus.fifo_count) > maxCount) maxCount = int'(bus.fifo_count);
    end
  end

  // Presents one result and holds valid until the acknowledge is seen.
  task automatic applyStimulus(input logic [ID_SIZE-1:0] id, input logic c, input logic [DATA_SIZE-1:0] sum);
    int cyc = 0;
    @(negedge clk);
    bus.a_valid_res = 1'b1;
    bus.result_add  = {id, c, sum};
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!bus.sum_written && cyc < 20);
    if (!bus.sum_written) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL ack_timeout: got no sum_written, expected one for id %0h", id);
    end
    bus.a_valid_res = 1'b0;
  endtask

  function automatic logic [ID_SIZE-1:0] idOf(input logic [RES_SIZE-1:0] w);
    logic [RES_SIZE-1:0] t;
    t = w;
    return t[RES_SIZE-1 -: ID_SIZE];
  endfunction

  task automatic drain();
    bus.res_ready = 1'b1;
    repeat (FIFO_DEPTH + 1) @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  logic [31:0] rnd;

  initial begin
    bus.a_valid_res = 1'b0;
    bus.result_add  = '0;
    bus.res_ready   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_sw", 32'(bus.sum_written), 32'd0);
    checkOutput("reset_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("reset_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("reset_ready", 32'(bus.ready_f_res), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single result, valid held through the acknowledge cycle.
    @(negedge clk);
    bus.a_valid_res = 1'b1;
    bus.result_add  = {8'h5A, 1'b1, 16'h0003};
    #1;
    checkOutput("single_sw_before", 32'(bus.sum_written), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("single_sw", 32'(bus.sum_written), 32'd1);
    checkOutput("single_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("single_data", 32'(bus.res_data), 32'h00B5_0003);
    checkOutput("single_count", 32'(bus.fifo_count), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("hold_sw_once", 32'(bus.sum_written), 32'd0);
    checkOutput("hold_count", 32'(bus.fifo_count), 32'd1);
    bus.a_valid_res = 1'b0;
    drain();

    // Fill to full, then a fifth result stalls until one pop.
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b0, 16'(i * 16'h0101));
    @(negedge clk);
    #1;
    checkOutput("full_count", 32'(bus.fifo_count), 32'd4);
    checkOutput("full_ready", 32'(bus.ready_f_res), 32'd0);
    bus.a_valid_res = 1'b1;
    bus.result_add  = {8'd5, 1'b1, 16'h0505};
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("stall_sw", 32'(bus.sum_written), 32'd0);
      checkOutput("stall_count", 32'(bus.fifo_count), 32'd4);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    checkOutput("pop_no_push_count", 32'(bus.fifo_count), 32'd3);
    checkOutput("pop_no_push_sw", 32'(bus.sum_written), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("late_push_sw", 32'(bus.sum_written), 32'd1);
    checkOutput("late_push_count", 32'(bus.fifo_count), 32'd4);
    bus.a_valid_res = 1'b0;
    dutPopQ.delete();
    bus.res_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    checkOutput("full_pop_total", 32'(dutPopQ.size()), 32'd4);
    for (int i = 0; i < 4 && i < dutPopQ.size(); i++)
      checkOutput("full_order", 32'(idOf(dutPopQ[i])), 32'(i + 2));
    checkOutput("full_drained", 32'(bus.fifo_count), 32'd0);

    // Simultaneous push and pop at count two.
    applyStimulus(8'h10, 1'b0, 16'h1010);
    applyStimulus(8'h11, 1'b1, 16'h1111);
    @(negedge clk);
    bus.a_valid_res = 1'b1;
    bus.result_add  = {8'h12, 1'b0, 16'h1212};
    bus.res_ready   = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    checkOutput("pushpop_count", 32'(bus.fifo_count), 32'd2);
    checkOutput("pushpop_head", 32'(idOf(bus.res_data)), 32'h11);
    checkOutput("pushpop_sw", 32'(bus.sum_written), 32'd1);
    bus.a_valid_res = 1'b0;
    drain();

    // Continuous streaming wraps both pointers.
    @(negedge clk);
    dutPopQ.delete();
    maxCount = 0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(8'(8'h20 + i), 1'(i), 16'(i * 7));
    repeat (2) @(negedge clk);
    bus.res_ready = 1'b0;
    checkOutput("wrap_total", 32'(dutPopQ.size()), 32'd10);
    for (int i = 0; i < 10 && i < dutPopQ.size(); i++)
      checkOutput("wrap_order", 32'(idOf(dutPopQ[i])), 32'(8'h20 + i));
    checkOutput("wrap_max_count", 32'(maxCount), 32'd1);

    // Reset during the acknowledge cycle with three entries stored.
    applyStimulus(8'h30, 1'b0, 16'h3030);
    applyStimulus(8'h31, 1'b0, 16'h3131);
    @(negedge clk);
    bus.a_valid_res = 1'b1;
    bus.result_add  = {8'h32, 1'b1, 16'h3232};
    @(negedge clk);
    #1;
    checkOutput("rst_pre_sw", 32'(bus.sum_written), 32'd1);
    checkOutput("rst_pre_count", 32'(bus.fifo_count), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_sw", 32'(bus.sum_written), 32'd0);
    checkOutput("rst_mid_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_mid_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("rst_mid_ready", 32'(bus.ready_f_res), 32'd1);
    bus.a_valid_res = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h40, 1'b0, 16'h4040);
    checkOutput("post_rst_count", 32'(bus.fifo_count), 32'd1);
    checkOutput("post_rst_head", 32'(idOf(bus.res_data)), 32'h40);
    drain();

    // Randomized traffic: adder protocol on the input, biased consumer readiness.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (bus.a_valid_res && bus.sum_written) begin
        bus.a_valid_res = 1'b0;
      end else if (!bus.a_valid_res && $urandom_range(0, 2) == 0) begin
        rnd = $urandom;
        bus.a_valid_res = 1'b1;
        bus.result_add  = rnd[RES_SIZE-1:0];
      end
      if (cyc < 300) bus.res_ready = ($urandom_range(0, 3) == 0);
      else           bus.res_ready = ($urandom_range(0, 3) != 0);
    end
    bus.a_valid_res = 1'b0;
    bus.res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
